ff_excitation_driver: RTL and testbench

FF_EXCITATION_DRIVER -- requirements
Module: ff_excitation_driver

---
 rtl/ff_excitation_driver.sv | 145 ++++++++++++++
 tb/tb_ff_excitation_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_excitation_driver.sv
// Flip-flop excitation driver: turns a desired next state into SR/JK/D/T
// excitation inputs, applies them to an emulated register and self-checks
// that the register reached the requested state.
module ff_excitation_driver #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             tgt,
    input  logic                         tgt_valid,
    output logic                         tgt_ready,
    output logic [WIDTH-1:0]             exc_a,
    output logic [WIDTH-1:0]             exc_b,
    output logic                         exc_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         done,
    output logic                         match,
    output logic [$clog2(WIDTH+1)-1:0]   chg_cnt,
    output logic                         err
);

    localparam int CW = $clog2(WIDTH+1);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXCITE = 2'b01,
        CHECK  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lat_tgt;
    logic [1:0]       lat_mode;
    logic             accept;

    // Input A: set/J for 0->1 bits, the target itself for D, changed bits for T.
    function automatic logic [WIDTH-1:0] exc_a_of(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] nxt);
        case (m)
            MODE_SR, MODE_JK: exc_a_of = ~cur & nxt;
            MODE_D:           exc_a_of = nxt;
            default:          exc_a_of = cur ^ nxt;
        endcase
    endfunction

    // Input B: reset/K for 1->0 bits; unused (zero) for D and T. S and R are
    // disjoint by construction, so S=R=1 can never be driven.
    function automatic logic [WIDTH-1:0] exc_b_of(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] nxt);
        case (m)
            MODE_SR, MODE_JK: exc_b_of = cur & ~nxt;
            default:          exc_b_of = '0;
        endcase
    endfunction

    // Characteristic equation of each flip-flop type.
    function automatic logic [WIDTH-1:0] next_q(input logic [1:0] m,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (m)
            MODE_SR: next_q = a | (cur & ~b);
            MODE_JK: next_q = (a & ~cur) | (~b & cur);
            MODE_D:  next_q = a;
            default: next_q = cur ^ a;
        endcase
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        popcount = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcount = popcount + CW'(v[i]);
        end
    endfunction

    assign accept = tgt_valid && tgt_ready;

    // Request latch: target and mode captured at accept for CHECK and q update.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_tgt  <= tgt;
            lat_mode <= mode;
        end
    end

    // Control FSM with registered handshake, strobe and emulated register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tgt_ready <= 1'b1;
            exc_valid <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            q         <= '0;
            exc_a     <= '0;
            exc_b     <= '0;
            chg_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tgt_valid) begin
                        exc_a     <= exc_a_of(mode, q, tgt);
                        exc_b     <= exc_b_of(mode, q, tgt);
                        chg_cnt   <= popcount(q ^ tgt);
                        tgt_ready <= 1'b0;
                        exc_valid <= 1'b1;
                        state     <= EXCITE;
                    end
                end
                EXCITE: begin
                    q         <= next_q(lat_mode, q, exc_a, exc_b);
                    match     <= (next_q(lat_mode, q, exc_a, exc_b) == lat_tgt);
                    exc_valid <= 1'b0;
                    done      <= 1'b1;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (!match) begin
                        err <= 1'b1;
                    end
                    done      <= 1'b0;
                    match     <= 1'b0;
                    tgt_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    tgt_ready <= 1'b1;
                    exc_valid <= 1'b0;
                    done      <= 1'b0;
                    match     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Self-checking bench for ff_excitation_driver (WIDTH=4): directed cases,
// back-to-back held requests, reset abort and a randomized run against a
// per-bit flip-flop reference model.
module tb_ff_excitation_driver;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic [WIDTH-1:0] tgt;
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] exc_a;
    logic [WIDTH-1:0] exc_b;
    logic             exc_valid;
    logic [WIDTH-1:0] q;
    logic             done;
    logic             match;
    logic [2:0]       chg_cnt;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_q;

    ff_excitation_driver #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .exc_a     (exc_a),
        .exc_b     (exc_b),
        .exc_valid (exc_valid),
        .q         (q),
        .done      (done),
        .match     (match),
        .chg_cnt   (chg_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: excitation table and characteristic behaviour bit by bit.
    task automatic model(input logic [1:0] m, input logic [WIDTH-1:0] cur,
                         input logic [WIDTH-1:0] nxt,
                         output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb,
                         output logic [WIDTH-1:0] nq, output int cnt);
        cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ea[i] = 1'b0;
            eb[i] = 1'b0;
            if (cur[i] != nxt[i]) cnt++;
            case (m)
                2'b00, 2'b01: begin
                    if (!cur[i] && nxt[i]) ea[i] = 1'b1;
                    if (cur[i] && !nxt[i]) eb[i] = 1'b1;
                end
                2'b10: ea[i] = nxt[i];
                default: ea[i] = (cur[i] != nxt[i]);
            endcase
            case (m)
                2'b00: nq[i] = ea[i] ? 1'b1 : (eb[i] ? 1'b0 : cur[i]);
                2'b01: begin
                    if (ea[i] && eb[i])  nq[i] = !cur[i];
                    else if (ea[i])      nq[i] = 1'b1;
                    else if (eb[i])      nq[i] = 1'b0;
                    else                 nq[i] = cur[i];
                end
                2'b10: nq[i] = ea[i];
                default: nq[i] = ea[i] ? !cur[i] : cur[i];
            endcase
        end
    endtask

    task automatic do_req(input logic [1:0] m, input logic [WIDTH-1:0] t);
        logic [WIDTH-1:0] ea, eb, nq;
        int cnt;
        model(m, m_q, t, ea, eb, nq, cnt);
        check_val("model_reaches_tgt", 32'(nq), 32'(t));
        tgt_valid = 1'b1;
        mode      = m;
        tgt       = t;
        check_val("idle_ready", 32'(tgt_ready), 32'd1);
        step();
        tgt_valid = 1'b0;
        mode      = 2'($urandom);
        tgt       = WIDTH'($urandom);
        check_val("exc_valid", 32'(exc_valid), 32'd1);
        check_val("excite_ready", 32'(tgt_ready), 32'd0);
        check_val("excite_done", 32'(done), 32'd0);
        check_val("exc_a", 32'(exc_a), 32'(ea));
        check_val("exc_b", 32'(exc_b), 32'(eb));
        check_val("chg_cnt", 32'(chg_cnt), 32'(cnt));
        if (m == 2'b00)
            check_val("sr_no_s_and_r", 32'(exc_a & exc_b), 32'd0);
        step();
        check_val("check_done", 32'(done), 32'd1);
        check_val("check_match", 32'(match), 32'd1);
        check_val("check_q", 32'(q), 32'(nq));
        check_val("check_exc_valid", 32'(exc_valid), 32'd0);
        check_val("exc_a_hold", 32'(exc_a), 32'(ea));
        check_val("exc_b_hold", 32'(exc_b), 32'(eb));
        check_val("chg_cnt_hold", 32'(chg_cnt), 32'(cnt));
        m_q = nq;
        step();
        check_val("post_done", 32'(done), 32'd0);
        check_val("post_ready", 32'(tgt_ready), 32'd1);
        check_val("post_err", 32'(err), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] t;
        rst       = 1'b1;
        tgt_valid = 1'b0;
        mode      = 2'b00;
        tgt       = '0;
        m_q       = '0;
        step();
        step();
        check_val("rst_q", 32'(q), 32'd0);
        check_val("rst_exc_a", 32'(exc_a), 32'd0);
        check_val("rst_exc_b", 32'(exc_b), 32'd0);
        check_val("rst_chg_cnt", 32'(chg_cnt), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_exc_valid", 32'(exc_valid), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_match", 32'(match), 32'd0);
        check_val("rst_ready", 32'(tgt_ready), 32'd1);
        rst = 1'b0;
        step();

        // Directed walk: SR, JK, T, then D with no change.
        do_req(2'b00, 4'b1010);
        check_val("sr_q_literal", 32'(q), 32'hA);
        do_req(2'b01, 4'b0110);
        check_val("jk_q_literal", 32'(q), 32'h6);
        do_req(2'b11, 4'b1001);
        check_val("t_q_literal", 32'(q), 32'h9);
        do_req(2'b10, 4'b1001);
        check_val("d_q_literal", 32'(q), 32'h9);

        // Request held high: accepts every third cycle, busy inputs ignored.
        t = WIDTH'($urandom);
        tgt_valid = 1'b1;
        mode      = 2'b10;
        tgt       = t;
        for (int k = 1; k <= 6; k++) begin
            step();
            check_val("held_ready", 32'(tgt_ready), 32'((k % 3) == 0));
            check_val("held_done", 32'(done), 32'((k % 3) == 2));
            if (k == 1 || k == 4) begin
                check_val("held_exc_a", 32'(exc_a), 32'(t));
                mode = 2'($urandom);
                tgt  = ~t;
            end
            if (k == 2 || k == 5)
                check_val("held_q", 32'(q), 32'(t));
            if (k == 3) begin
                mode = 2'b10;
                tgt  = t;
            end
            if (k == 4)
                check_val("held_chg_cnt", 32'(chg_cnt), 32'd0);
        end
        tgt_valid = 1'b0;
        m_q = t;
        step();

        // Reset during EXCITE aborts the request.
        tgt_valid = 1'b1;
        mode      = 2'b11;
        tgt       = ~m_q;
        step();
        tgt_valid = 1'b0;
        check_val("abort_in_excite", 32'(exc_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("abort_ready", 32'(tgt_ready), 32'd1);
        check_val("abort_q", 32'(q), 32'd0);
        check_val("abort_exc_valid", 32'(exc_valid), 32'd0);
        check_val("abort_done", 32'(done), 32'd0);
        check_val("abort_err", 32'(err), 32'd0);
        step();
        check_val("abort_no_late_done", 32'(done), 32'd0);
        check_val("abort_q_stays", 32'(q), 32'd0);
        m_q = '0;

        // Randomized run.
        for (int n = 0; n < 60; n++) begin
            do_req(2'($urandom), WIDTH'($urandom));
        end
        check_val("final_err", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
